// File: rtl/fifo1_pkg.sv
// Shared constants for the async FIFO pointer/flag blocks and synchronizers.
//   DEFAULT_ASIZE : default address width (FIFO depth = 2**DEFAULT_ASIZE)
//   PTR_W         : pointer width for the default configuration (one extra wrap bit)
package fifo1_pkg;

    localparam int unsigned DEFAULT_ASIZE = 4;
    localparam int unsigned PTR_W         = DEFAULT_ASIZE + 1;

endpackage

// File: rtl/rptr_empty_if.sv
// Read-side bus of the async FIFO: consumer pop request, synchronized write pointer,
// and the read-domain pointer/flag outputs.
//   slave  : the rptr_empty block (takes rinc/rq2_wptr, drives the rest)
//   master : the consumer / environment side
interface rptr_empty_if
    import fifo1_pkg::*;
#(
    parameter int unsigned ASIZE = DEFAULT_ASIZE
) ();

    logic             rinc;        // pop request
    logic [ASIZE:0]   rq2_wptr;    // Gray write pointer already in rclk domain
    logic [ASIZE-1:0] raddr;       // binary RAM read address
    logic [ASIZE:0]   rptr;        // Gray read pointer toward write domain
    logic             rempty;      // FIFO empty
    logic             raempty;     // almost empty
    logic [ASIZE:0]   rlevel;      // occupancy seen from read domain
    logic             runderflow;  // sticky pop-while-empty

    modport slave (
        input  rinc, rq2_wptr,
        output raddr, rptr, rempty, raempty, rlevel, runderflow
    );

    modport master (
        output rinc, rq2_wptr,
        input  raddr, rptr, rempty, raempty, rlevel, runderflow
    );

endinterface

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter, shared by the read- and write-side blocks.
//   gray_i : Gray-coded value
//   bin_o  : equivalent binary value
module gray2bin
    import fifo1_pkg::*;
#(
    parameter int unsigned WIDTH = PTR_W
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    // Each binary bit is the XOR of all Gray bits at or above its position.
    always_comb begin
        bin_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin_o[i] = ^(gray_i >> i);
        end
    end

endmodule

// File: rtl/rptr_empty.sv
// Read-pointer and empty-flag logic of an async FIFO (read clock domain).
//   rclk   : read clock, sole clock of the block
//   rrst_n : synchronous active-low reset
//   bus    : rptr_empty_if.slave -- rinc/rq2_wptr in; raddr, rptr, rempty, raempty,
//            rlevel, runderflow out (all registered except raddr, a slice of rbin)
module rptr_empty
    import fifo1_pkg::*;
#(
    parameter int unsigned ASIZE     = DEFAULT_ASIZE,
    parameter int unsigned AEMPTY_TH = 2
) (
    input  logic         rclk,
    input  logic         rrst_n,
    rptr_empty_if.slave  bus
);

    localparam int unsigned PtrW = ASIZE + 1;

    logic [PtrW-1:0] rbin_q, rbin_d;
    logic [PtrW-1:0] rptr_q, rgray_d;
    logic [PtrW-1:0] rlevel_q, rlevel_d;
    logic [PtrW-1:0] wbin;
    logic            rempty_q, rempty_d;
    logic            raempty_q, raempty_d;
    logic            runderflow_q, runderflow_d;
    logic            pop;

    gray2bin #(
        .WIDTH (PtrW)
    ) u_wptr_g2b (
        .gray_i (bus.rq2_wptr),
        .bin_o  (wbin)
    );

    always_comb begin
        pop          = bus.rinc & ~rempty_q;
        rbin_d       = rbin_q + PtrW'(pop);
        rgray_d      = (rbin_d >> 1) ^ rbin_d;
        // Compare against the post-pop pointer so a draining pop flags empty on the same edge.
        rempty_d     = (rgray_d == bus.rq2_wptr);
        // Modulo 2**PtrW difference: the extra wrap bit lets a full FIFO read 2**ASIZE, not 0.
        rlevel_d     = wbin - rbin_d;
        raempty_d    = (32'(rlevel_d) <= AEMPTY_TH);
        runderflow_d = runderflow_q | (bus.rinc & rempty_q);
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            rbin_q       <= '0;
            rptr_q       <= '0;
            rlevel_q     <= '0;
            rempty_q     <= 1'b1;
            raempty_q    <= 1'b1;
            runderflow_q <= 1'b0;
        end else begin
            rbin_q       <= rbin_d;
            rptr_q       <= rgray_d;
            rlevel_q     <= rlevel_d;
            rempty_q     <= rempty_d;
            raempty_q    <= raempty_d;
            runderflow_q <= runderflow_d;
        end
    end

    assign bus.raddr      = rbin_q[ASIZE-1:0];
    assign bus.rptr       = rptr_q;
    assign bus.rempty     = rempty_q;
    assign bus.raempty    = raempty_q;
    assign bus.rlevel     = rlevel_q;
    assign bus.runderflow = runderflow_q;

endmodule

// File: tb/tb_rptr_empty.sv
// Self-checking bench for rptr_empty (ASIZE=4, AEMPTY_TH=2): directed scenarios followed
// by randomized traffic, all compared against a count-based reference model.
module tb_rptr_empty;

    localparam int unsigned ASIZE = 4;

    logic rclk   = 1'b0;
    logic rrst_n = 1'b0;

    rptr_empty_if #(.ASIZE(ASIZE)) bus ();

    rptr_empty #(
        .ASIZE     (ASIZE),
        .AEMPTY_TH (2)
    ) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (bus)
    );

    always #5 rclk = ~rclk;

    int tests = 0;
    int fails = 0;

    // Reference model: total pops accepted and total writes, kept as plain counts.
    int rd      = 0;
    int w       = 0;
    int m_level = 0;
    bit m_empty = 1'b1;
    bit m_aempty = 1'b1;
    bit m_uflow = 1'b0;

    function automatic logic [4:0] gray(input int n);
        logic [4:0] b;
        b = 5'(n & 31);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the model on the edge, then check every output.
    task automatic step(input bit inc, input int wc, input bit rst);
        bus.rinc     = inc;
        bus.rq2_wptr = gray(wc);
        rrst_n       = ~rst;
        @(posedge rclk);
        if (rst) begin
            rd       = 0;
            m_level  = 0;
            m_empty  = 1'b1;
            m_aempty = 1'b1;
            m_uflow  = 1'b0;
        end else begin
            if (inc && m_empty) m_uflow = 1'b1;
            if (inc && !m_empty) rd++;
            m_level  = (wc - rd) & 31;
            m_empty  = (m_level == 0);
            m_aempty = (m_level <= 2);
        end
        #1;
        chk("raddr", 32'(bus.raddr), 32'(rd & 15));
        chk("rptr", 32'(bus.rptr), 32'(gray(rd)));
        chk("rempty", 32'(bus.rempty), 32'(m_empty));
        chk("raempty", 32'(bus.raempty), 32'(m_aempty));
        chk("rlevel", 32'(bus.rlevel), 32'(m_level));
        chk("runderflow", 32'(bus.runderflow), 32'(m_uflow));
    endtask

    bit r_rst;
    bit r_inc;
    int nw;

    initial begin
        bus.rinc     = 1'b0;
        bus.rq2_wptr = '0;

        // Reset with pop requested and a nonzero write pointer (gray(6) = 0x05).
        step(1'b1, 6, 1'b1);
        step(1'b1, 6, 1'b1);
        chk("rst_rempty", 32'(bus.rempty), 32'd1);
        chk("rst_raempty", 32'(bus.raempty), 32'd1);
        chk("rst_rlevel", 32'(bus.rlevel), 32'd0);
        chk("rst_raddr", 32'(bus.raddr), 32'd0);
        chk("rst_rptr", 32'(bus.rptr), 32'd0);
        chk("rst_uflow", 32'(bus.runderflow), 32'd0);

        // Fill to 3, then one pop.
        step(1'b0, 0, 1'b0);
        step(1'b0, 3, 1'b0);
        chk("fill_rempty", 32'(bus.rempty), 32'd0);
        chk("fill_rlevel", 32'(bus.rlevel), 32'd3);
        chk("fill_raempty", 32'(bus.raempty), 32'd0);
        step(1'b1, 3, 1'b0);
        chk("pop_raddr", 32'(bus.raddr), 32'd1);
        chk("pop_rptr", 32'(bus.rptr), 32'h01);
        chk("pop_rlevel", 32'(bus.rlevel), 32'd2);
        chk("pop_raempty", 32'(bus.raempty), 32'd1);

        // Drain, then pop while empty.
        step(1'b1, 3, 1'b0);
        step(1'b1, 3, 1'b0);
        chk("drain_rempty", 32'(bus.rempty), 32'd1);
        step(1'b1, 3, 1'b0);
        chk("uf_raddr", 32'(bus.raddr), 32'd3);
        chk("uf_rptr", 32'(bus.rptr), 32'h02);
        chk("uf_set", 32'(bus.runderflow), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 3, 1'b0);
            chk("uf_sticky", 32'(bus.runderflow), 32'd1);
        end

        // Wrap of the binary pointer through 16.
        step(1'b0, 0, 1'b1);
        step(1'b0, 16, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 16, 1'b0);
        chk("wrap_rptr16", 32'(bus.rptr), 32'h18);
        chk("wrap_empty16", 32'(bus.rempty), 32'd1);
        step(1'b0, 17, 1'b0);
        chk("wrap_rlevel1", 32'(bus.rlevel), 32'd1);
        step(1'b1, 17, 1'b0);
        chk("wrap_raddr", 32'(bus.raddr), 32'd1);
        chk("wrap_rptr", 32'(bus.rptr), 32'h19);
        chk("wrap_rempty", 32'(bus.rempty), 32'd1);
        chk("wrap_rlevel0", 32'(bus.rlevel), 32'd0);

        // Full level must read 16, not alias to 0.
        step(1'b0, 0, 1'b1);
        step(1'b0, 16, 1'b0);
        chk("full_rlevel", 32'(bus.rlevel), 32'd16);
        chk("full_rempty", 32'(bus.rempty), 32'd0);
        chk("full_raempty", 32'(bus.raempty), 32'd0);

        // Reset in the middle of a pop.
        step(1'b0, 0, 1'b1);
        step(1'b0, 5, 1'b0);
        chk("mid_rlevel5", 32'(bus.rlevel), 32'd5);
        step(1'b1, 5, 1'b1);
        chk("mid_rempty", 32'(bus.rempty), 32'd1);
        chk("mid_raempty", 32'(bus.raempty), 32'd1);
        chk("mid_rlevel", 32'(bus.rlevel), 32'd0);
        chk("mid_raddr", 32'(bus.raddr), 32'd0);
        chk("mid_rptr", 32'(bus.rptr), 32'd0);
        chk("mid_uflow", 32'(bus.runderflow), 32'd0);
        step(1'b0, 0, 1'b0);
        step(1'b0, 2, 1'b0);
        chk("post_rst_raddr", 32'(bus.raddr), 32'd0);
        step(1'b1, 2, 1'b0);
        chk("post_rst_pop", 32'(bus.raddr), 32'd1);

        // Randomized traffic, writer never more than 16 entries ahead.
        w = 2;
        for (int i = 0; i < 3000; i++) begin
            r_rst = ($urandom_range(0, 299) == 0);
            r_inc = ($urandom_range(0, 3) < (((i / 150) % 2 == 1) ? 3 : 1));
            if (r_rst) begin
                w = 0;
            end else begin
                nw = w + int'($urandom_range(0, 2));
                if (nw > rd + 16) nw = rd + 16;
                w = nw;
            end
            step(r_inc, w, r_rst);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rptr_empty.md
RPTR_EMPTY -- requirements
Module: rptr_empty

Interface
REQ-001 Parameter: ASIZE, 4, address width; FIFO depth = 2^ASIZE, pointer width ASIZE+1.
REQ-002 Parameter: AEMPTY_TH, 2, almost-empty threshold in entries (0..2^ASIZE).
REQ-003 Port: rclk  in  1  read-domain clock; sole clock of the block.
REQ-004 Port: rrst_n  in  1  reset, synchronous to rclk, active-low.
REQ-005 Port: rinc  in  1  read request (pop) from consumer.
REQ-006 Port: rq2_wptr  in  ASIZE+1  Gray write pointer, already synchronized into rclk domain.
REQ-007 Port: raddr  out  ASIZE  binary RAM read address.
REQ-008 Port: rptr  out  ASIZE+1  Gray read pointer, registered, for the read-to-write synchronizer.
REQ-009 Port: rempty  out  1  FIFO empty flag.
REQ-010 Port: raempty  out  1  almost-empty flag.
REQ-011 Port: rlevel  out  ASIZE+1  occupancy as seen from read domain, 0..2^ASIZE.
REQ-012 Port: runderflow  out  1  sticky error: pop attempted while empty.

Function
REQ-013 Internal binary pointer rbin (ASIZE+1 bits); raddr SHALL equal rbin[ASIZE-1:0].
REQ-014 Accepted pop = rinc & ~rempty; rbinnext SHALL be rbin + accepted pop, modulo 2^(ASIZE+1).
REQ-015 rgraynext SHALL be (rbinnext >> 1) ^ rbinnext; rptr SHALL register rgraynext each cycle.
REQ-016 rempty SHALL register (rgraynext == rq2_wptr); a pop emptying the FIFO asserts rempty on the same edge that advances raddr.
REQ-017 A change on rq2_wptr SHALL be reflected in rempty, rlevel and raempty exactly one rclk edge later; no extra synchronizer stages inside this block.
REQ-018 rlevel SHALL register (gray2bin(rq2_wptr) - rbinnext) modulo 2^(ASIZE+1).
REQ-019 raempty SHALL register (next rlevel <= AEMPTY_TH); rempty implies raempty.
REQ-020 rinc while rempty=1 SHALL leave rbin, raddr, rptr unchanged and set runderflow on the next edge; runderflow holds until reset.
REQ-021 Pointer wrap at 2^(ASIZE+1) SHALL be seamless; raddr wraps at 2^ASIZE; rlevel SHALL report 2^ASIZE when full without aliasing to 0.
REQ-022 Simultaneous pop and rq2_wptr change in one cycle SHALL both be accounted in the registered outputs of the next edge.

Reset
REQ-023 While rrst_n=0 at a rising rclk edge: rbin=0, raddr=0, rptr=0, rempty=1, raempty=1, rlevel=0, runderflow=0, regardless of rinc or rq2_wptr.
REQ-024 Reset asserted mid-operation SHALL discard in-flight state at that edge; first accepted pop after release reads raddr=0.
REQ-025 No asynchronous reset path; every flop resets only on rclk.

Structure
REQ-026 Shared package fifo1_pkg SHALL hold ASIZE default and pointer-width constant (PTR_W = ASIZE+1) used by both pointer/flag blocks and synchronizers.
REQ-027 Gray-to-binary conversion SHALL be one combinational sub-module gray2bin, parameterized by width, reusable by the write-side block.
REQ-028 All outputs SHALL be driven directly from flops except raddr (slice of rbin flop).

Verification (ASIZE=4, AEMPTY_TH=2)
REQ-029 Reset: rrst_n=0 for 2 edges with rinc=1, rq2_wptr=0x05 -> rempty=1, raempty=1, rlevel=0, raddr=0, rptr=0, runderflow=0.
REQ-030 Fill/pop: rq2_wptr 0x00->0x02 (gray 3) -> next edge rempty=0, rlevel=3, raempty=0; one pop -> raddr=1, rptr=0x01, rlevel=2, raempty=1.
REQ-031 Underflow: rempty=1, rinc=1 one cycle -> raddr, rptr unchanged, runderflow=1 next edge and stays 1 for 10 further cycles.
REQ-032 Wrap: rbin=16 (rptr=0x18), rq2_wptr=0x19 -> rlevel=1; pop -> raddr=1, rptr=0x19, rempty=1, rlevel=0.
REQ-033 Full level: rbin=0, rq2_wptr=0x18 (gray 16) -> rlevel=16, rempty=0, raempty=0.
REQ-034 Mid-op reset: rlevel=5, pop in progress, rrst_n=0 one edge -> all outputs at REQ-023 values on that edge.
